aes128_iter_encrypt: RTL and testbench
======================================

Name: aes128_iter_encrypt

Overview:
- Iterative AES-128 encryption engine (FIPS-197) that processes one round per clock and expands round keys on the fly.
- Free-running: it samples plaintext and key, produces the ciphertext 11 cycles later, then immediately starts the next block.
- Sits as the cipher core behind a register-level wrapper; it has no backpressure.

Parameters:
- None. Nk=4, Nr=10 and block width 128 are fixed constants in the package.

Ports:
- i_AES_clk  in  1  rising-edge clock.
- i_AES_rst  in  1  synchronous reset, active-high.
- i_AES_plain_text  in  128  plaintext block; bits [127:120] are byte 0.
- i_AES_key_in  in  128  cipher key; bits [127:120] are byte 0.
- o_AES_data_encrypted  out  128  registered ciphertext; holds its value between updates.
- o_AES_valid  out  1  one-cycle pulse, high in the cycle o_AES_data_encrypted takes a new ciphertext.

Behaviour:
- Clocking and reset: one clock, i_AES_clk. Reset is synchronous and active-high on i_AES_rst.
- While reset is high, at each edge:
  - round counter <= 0 (LOAD);
  - state and round-key registers <= 0;
  - o_AES_data_encrypted <= 0 and o_AES_valid <= 0.
- Reset asserted mid-block aborts the block: no valid pulse and no output change other than clearing.
- State byte mapping: byte k sits at bits [127-8k -: 8]; state s[r][c] = byte 4c+r (column-major).
- Counter values 0..10 are sequenced as follows:
  - LOAD (cnt=0): state <= plain_text ^ key_in; rk <= key_in; cnt <= 1. Inputs are sampled only at this edge; changes at any other time are ignored for the block in flight.
  - Rounds 1..9 (cnt=1..9): nrk = KeyExpand(rk, rcon[cnt]); state <= MixColumns(ShiftRows(SubBytes(state))) ^ nrk; rk <= nrk; cnt++.
  - Round 10 (cnt=10): nrk = KeyExpand(rk, 8'h36). The result SubBytes→ShiftRows→^nrk goes directly to o_AES_data_encrypted, with no MixColumns. At the same edge o_AES_valid <= 1 and cnt <= 0.
  - Every other edge: o_AES_valid <= 0.
- Timing:
  - First LOAD edge is the first rising edge with i_AES_rst low.
  - Ciphertext appears 10 edges after the LOAD edge.
  - Throughput is one block per 11 cycles, back-to-back, no idle cycle.
- KeyExpand(rk, rc), with words w0..w3 where w0 = rk[127:96]:
  - t = SubWord(RotWord(w3)) ^ {rc, 24'h0};
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
- rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- MixColumns:
  - Operates over GF(2^8) modulo x^8+x^4+x^3+x+1.
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).
  - Coefficient matrix rows: (02 03 01 01), (01 02 03 01), (01 01 02 03), (03 01 01 02).
- ShiftRows: row r rotates left by r columns.
- Combinational path per cycle: one SubBytes + ShiftRows + MixColumns + AddRoundKey, plus key expansion in parallel. The only sequential elements are the counter, state, rk and the two outputs.
- X on the inputs at a LOAD edge yields an X block. The design does not guard against this; the bench drives inputs before reset release.

Decomposition:
- Package aes_pkg holds:
  - constants NR=10 and the rcon array;
  - functions xtime, mix_column (32-bit), shift_rows (128-bit);
  - the counter width (4 bits).
- Sub-module aes_sbox: combinational 8-bit S-box as a 256-entry case table.
  - 20 instances: 16 for SubBytes, 4 for SubWord.
- The top holds the counter, registers and round/key datapath.

Test Plan:
- FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, applied before reset release. Expect ct 3925841d02dc09fbdc118597196a0b32 with o_AES_valid high exactly on the 11th edge after reset release.
- FIPS-197 App. C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f. Expect 69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero pt and key: expect 66e94bd4ef8a2c3b884cfa59ca342b2e. The valid pulse repeats every 11 cycles with an identical output.
- Inputs changed at cycle 3 of a block: the current output still equals the old vector; the next block (period later) produces the new vector's ciphertext.
- Reset asserted at cnt=5 for one cycle: outputs are 0 and valid is 0. The next valid arrives 11 edges after release with the correct ciphertext.
- Reset held: outputs stay 0 and valid never pulses.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and the pure byte/column helpers used by the round datapath.
package aes_pkg;
    localparam int NK      = 4;
    localparam int NR      = 10;
    localparam int BLOCK_W = 128;
    localparam int CNT_W   = 4;

    // Indexed directly by the round counter; entries past round 10 are never used.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte 4c+r of the result is taken from column (c+r)%4 of the same row.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    always_comb begin
        o_byte = 8'h00;
        case (i_byte)
            8'h00: o_byte = 8'h63; 8'h01: o_byte = 8'h7c; 8'h02: o_byte = 8'h77; 8'h03: o_byte = 8'h7b; 8'h04: o_byte = 8'hf2; 8'h05: o_byte = 8'h6b; 8'h06: o_byte = 8'h6f; 8'h07: o_byte = 8'hc5;
            8'h08: o_byte = 8'h30; 8'h09: o_byte = 8'h01; 8'h0a: o_byte = 8'h67; 8'h0b: o_byte = 8'h2b; 8'h0c: o_byte = 8'hfe; 8'h0d: o_byte = 8'hd7; 8'h0e: o_byte = 8'hab; 8'h0f: o_byte = 8'h76;
            8'h10: o_byte = 8'hca; 8'h11: o_byte = 8'h82; 8'h12: o_byte = 8'hc9; 8'h13: o_byte = 8'h7d; 8'h14: o_byte = 8'hfa; 8'h15: o_byte = 8'h59; 8'h16: o_byte = 8'h47; 8'h17: o_byte = 8'hf0;
            8'h18: o_byte = 8'had; 8'h19: o_byte = 8'hd4; 8'h1a: o_byte = 8'ha2; 8'h1b: o_byte = 8'haf; 8'h1c: o_byte = 8'h9c; 8'h1d: o_byte = 8'ha4; 8'h1e: o_byte = 8'h72; 8'h1f: o_byte = 8'hc0;
            8'h20: o_byte = 8'hb7; 8'h21: o_byte = 8'hfd; 8'h22: o_byte = 8'h93; 8'h23: o_byte = 8'h26; 8'h24: o_byte = 8'h36; 8'h25: o_byte = 8'h3f; 8'h26: o_byte = 8'hf7; 8'h27: o_byte = 8'hcc;
            8'h28: o_byte = 8'h34; 8'h29: o_byte = 8'ha5; 8'h2a: o_byte = 8'he5; 8'h2b: o_byte = 8'hf1; 8'h2c: o_byte = 8'h71; 8'h2d: o_byte = 8'hd8; 8'h2e: o_byte = 8'h31; 8'h2f: o_byte = 8'h15;
            8'h30: o_byte = 8'h04; 8'h31: o_byte = 8'hc7; 8'h32: o_byte = 8'h23; 8'h33: o_byte = 8'hc3; 8'h34: o_byte = 8'h18; 8'h35: o_byte = 8'h96; 8'h36: o_byte = 8'h05; 8'h37: o_byte = 8'h9a;
            8'h38: o_byte = 8'h07; 8'h39: o_byte = 8'h12; 8'h3a: o_byte = 8'h80; 8'h3b: o_byte = 8'he2; 8'h3c: o_byte = 8'heb; 8'h3d: o_byte = 8'h27; 8'h3e: o_byte = 8'hb2; 8'h3f: o_byte = 8'h75;
            8'h40: o_byte = 8'h09; 8'h41: o_byte = 8'h83; 8'h42: o_byte = 8'h2c; 8'h43: o_byte = 8'h1a; 8'h44: o_byte = 8'h1b; 8'h45: o_byte = 8'h6e; 8'h46: o_byte = 8'h5a; 8'h47: o_byte = 8'ha0;
            8'h48: o_byte = 8'h52; 8'h49: o_byte = 8'h3b; 8'h4a: o_byte = 8'hd6; 8'h4b: o_byte = 8'hb3; 8'h4c: o_byte = 8'h29; 8'h4d: o_byte = 8'he3; 8'h4e: o_byte = 8'h2f; 8'h4f: o_byte = 8'h84;
            8'h50: o_byte = 8'h53; 8'h51: o_byte = 8'hd1; 8'h52: o_byte = 8'h00; 8'h53: o_byte = 8'hed; 8'h54: o_byte = 8'h20; 8'h55: o_byte = 8'hfc; 8'h56: o_byte = 8'hb1; 8'h57: o_byte = 8'h5b;
            8'h58: o_byte = 8'h6a; 8'h59: o_byte = 8'hcb; 8'h5a: o_byte = 8'hbe; 8'h5b: o_byte = 8'h39; 8'h5c: o_byte = 8'h4a; 8'h5d: o_byte = 8'h4c; 8'h5e: o_byte = 8'h58; 8'h5f: o_byte = 8'hcf;
            8'h60: o_byte = 8'hd0; 8'h61: o_byte = 8'hef; 8'h62: o_byte = 8'haa; 8'h63: o_byte = 8'hfb; 8'h64: o_byte = 8'h43; 8'h65: o_byte = 8'h4d; 8'h66: o_byte = 8'h33; 8'h67: o_byte = 8'h85;
            8'h68: o_byte = 8'h45; 8'h69: o_byte = 8'hf9; 8'h6a: o_byte = 8'h02; 8'h6b: o_byte = 8'h7f; 8'h6c: o_byte = 8'h50; 8'h6d: o_byte = 8'h3c; 8'h6e: o_byte = 8'h9f; 8'h6f: o_byte = 8'ha8;
            8'h70: o_byte = 8'h51; 8'h71: o_byte = 8'ha3; 8'h72: o_byte = 8'h40; 8'h73: o_byte = 8'h8f; 8'h74: o_byte = 8'h92; 8'h75: o_byte = 8'h9d; 8'h76: o_byte = 8'h38; 8'h77: o_byte = 8'hf5;
            8'h78: o_byte = 8'hbc; 8'h79: o_byte = 8'hb6; 8'h7a: o_byte = 8'hda; 8'h7b: o_byte = 8'h21; 8'h7c: o_byte = 8'h10; 8'h7d: o_byte = 8'hff; 8'h7e: o_byte = 8'hf3; 8'h7f: o_byte = 8'hd2;
            8'h80: o_byte = 8'hcd; 8'h81: o_byte = 8'h0c; 8'h82: o_byte = 8'h13; 8'h83: o_byte = 8'hec; 8'h84: o_byte = 8'h5f; 8'h85: o_byte = 8'h97; 8'h86: o_byte = 8'h44; 8'h87: o_byte = 8'h17;
            8'h88: o_byte = 8'hc4; 8'h89: o_byte = 8'ha7; 8'h8a: o_byte = 8'h7e; 8'h8b: o_byte = 8'h3d; 8'h8c: o_byte = 8'h64; 8'h8d: o_byte = 8'h5d; 8'h8e: o_byte = 8'h19; 8'h8f: o_byte = 8'h73;
            8'h90: o_byte = 8'h60; 8'h91: o_byte = 8'h81; 8'h92: o_byte = 8'h4f; 8'h93: o_byte = 8'hdc; 8'h94: o_byte = 8'h22; 8'h95: o_byte = 8'h2a; 8'h96: o_byte = 8'h90; 8'h97: o_byte = 8'h88;
            8'h98: o_byte = 8'h46; 8'h99: o_byte = 8'hee; 8'h9a: o_byte = 8'hb8; 8'h9b: o_byte = 8'h14; 8'h9c: o_byte = 8'hde; 8'h9d: o_byte = 8'h5e; 8'h9e: o_byte = 8'h0b; 8'h9f: o_byte = 8'hdb;
            8'ha0: o_byte = 8'he0; 8'ha1: o_byte = 8'h32; 8'ha2: o_byte = 8'h3a; 8'ha3: o_byte = 8'h0a; 8'ha4: o_byte = 8'h49; 8'ha5: o_byte = 8'h06; 8'ha6: o_byte = 8'h24; 8'ha7: o_byte = 8'h5c;
            8'ha8: o_byte = 8'hc2; 8'ha9: o_byte = 8'hd3; 8'haa: o_byte = 8'hac; 8'hab: o_byte = 8'h62; 8'hac: o_byte = 8'h91; 8'had: o_byte = 8'h95; 8'hae: o_byte = 8'he4; 8'haf: o_byte = 8'h79;
            8'hb0: o_byte = 8'he7; 8'hb1: o_byte = 8'hc8; 8'hb2: o_byte = 8'h37; 8'hb3: o_byte = 8'h6d; 8'hb4: o_byte = 8'h8d; 8'hb5: o_byte = 8'hd5; 8'hb6: o_byte = 8'h4e; 8'hb7: o_byte = 8'ha9;
            8'hb8: o_byte = 8'h6c; 8'hb9: o_byte = 8'h56; 8'hba: o_byte = 8'hf4; 8'hbb: o_byte = 8'hea; 8'hbc: o_byte = 8'h65; 8'hbd: o_byte = 8'h7a; 8'hbe: o_byte = 8'hae; 8'hbf: o_byte = 8'h08;
            8'hc0: o_byte = 8'hba; 8'hc1: o_byte = 8'h78; 8'hc2: o_byte = 8'h25; 8'hc3: o_byte = 8'h2e; 8'hc4: o_byte = 8'h1c; 8'hc5: o_byte = 8'ha6; 8'hc6: o_byte = 8'hb4; 8'hc7: o_byte = 8'hc6;
            8'hc8: o_byte = 8'he8; 8'hc9: o_byte = 8'hdd; 8'hca: o_byte = 8'h74; 8'hcb: o_byte = 8'h1f; 8'hcc: o_byte = 8'h4b; 8'hcd: o_byte = 8'hbd; 8'hce: o_byte = 8'h8b; 8'hcf: o_byte = 8'h8a;
            8'hd0: o_byte = 8'h70; 8'hd1: o_byte = 8'h3e; 8'hd2: o_byte = 8'hb5; 8'hd3: o_byte = 8'h66; 8'hd4: o_byte = 8'h48; 8'hd5: o_byte = 8'h03; 8'hd6: o_byte = 8'hf6; 8'hd7: o_byte = 8'h0e;
            8'hd8: o_byte = 8'h61; 8'hd9: o_byte = 8'h35; 8'hda: o_byte = 8'h57; 8'hdb: o_byte = 8'hb9; 8'hdc: o_byte = 8'h86; 8'hdd: o_byte = 8'hc1; 8'hde: o_byte = 8'h1d; 8'hdf: o_byte = 8'h9e;
            8'he0: o_byte = 8'he1; 8'he1: o_byte = 8'hf8; 8'he2: o_byte = 8'h98; 8'he3: o_byte = 8'h11; 8'he4: o_byte = 8'h69; 8'he5: o_byte = 8'hd9; 8'he6: o_byte = 8'h8e; 8'he7: o_byte = 8'h94;
            8'he8: o_byte = 8'h9b; 8'he9: o_byte = 8'h1e; 8'hea: o_byte = 8'h87; 8'heb: o_byte = 8'he9; 8'hec: o_byte = 8'hce; 8'hed: o_byte = 8'h55; 8'hee: o_byte = 8'h28; 8'hef: o_byte = 8'hdf;
            8'hf0: o_byte = 8'h8c; 8'hf1: o_byte = 8'ha1; 8'hf2: o_byte = 8'h89; 8'hf3: o_byte = 8'h0d; 8'hf4: o_byte = 8'hbf; 8'hf5: o_byte = 8'he6; 8'hf6: o_byte = 8'h42; 8'hf7: o_byte = 8'h68;
            8'hf8: o_byte = 8'h41; 8'hf9: o_byte = 8'h99; 8'hfa: o_byte = 8'h2d; 8'hfb: o_byte = 8'h0f; 8'hfc: o_byte = 8'hb0; 8'hfd: o_byte = 8'h54; 8'hfe: o_byte = 8'hbb; 8'hff: o_byte = 8'h16;
            default: o_byte = 8'h00;
        endcase
    end
endmodule

// File: rtl/aes128_iter_encrypt.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion,
// free-running at one block every NR+1 cycles.
module aes128_iter_encrypt
    import aes_pkg::*;
(
    input  logic               i_AES_clk,
    input  logic               i_AES_rst,
    input  logic [BLOCK_W-1:0] i_AES_plain_text,
    input  logic [BLOCK_W-1:0] i_AES_key_in,
    output logic [BLOCK_W-1:0] o_AES_data_encrypted,
    output logic               o_AES_valid
);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLOCK_W-1:0] state_q, state_d;
    logic [BLOCK_W-1:0] rk_q, rk_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic               valid_q, valid_d;

    logic [BLOCK_W-1:0] sb_state, sr_state, mc_state, nrk;
    logic [31:0]        rot_w3, sub_w3, key_t;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_subbytes
            aes_sbox u_sbox (
                .i_byte (state_q[127-8*gi -: 8]),
                .o_byte (sb_state[127-8*gi -: 8])
            );
        end
        for (gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .i_byte (rot_w3[31-8*gi -: 8]),
                .o_byte (sub_w3[31-8*gi -: 8])
            );
        end
        for (gi = 0; gi < 4; gi++) begin : g_mix
            assign mc_state[127-32*gi -: 32] = mix_column(sr_state[127-32*gi -: 32]);
        end
    endgenerate

    assign rot_w3   = {rk_q[23:0], rk_q[31:24]};
    assign key_t    = sub_w3 ^ {RCON[cnt_q], 24'h0};
    assign sr_state = shift_rows(sb_state);

    // Each new key word chains off the previously derived one.
    always_comb begin
        nrk[127:96] = rk_q[127:96] ^ key_t;
        nrk[95:64]  = rk_q[95:64]  ^ nrk[127:96];
        nrk[63:32]  = rk_q[63:32]  ^ nrk[95:64];
        nrk[31:0]   = rk_q[31:0]   ^ nrk[63:32];
    end

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        rk_d    = rk_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (cnt_q == '0) begin
            state_d = i_AES_plain_text ^ i_AES_key_in;
            rk_d    = i_AES_key_in;
            cnt_d   = CNT_W'(1);
        end else if (cnt_q == CNT_W'(NR)) begin
            data_d  = sr_state ^ nrk;
            valid_d = 1'b1;
            cnt_d   = '0;
        end else if (cnt_q < CNT_W'(NR)) begin
            state_d = mc_state ^ nrk;
            rk_d    = nrk;
            cnt_d   = cnt_q + CNT_W'(1);
        end else begin
            cnt_d   = '0;
        end
    end

    always_ff @(posedge i_AES_clk) begin
        if (i_AES_rst) begin
            cnt_q   <= '0;
            state_q <= '0;
            rk_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_AES_data_encrypted = data_q;
    assign o_AES_valid          = valid_q;
endmodule

// File: tb/tb_aes128_iter_encrypt.sv
// Self-checking bench for aes128_iter_encrypt against a byte-array AES reference model.
module tb_aes128_iter_encrypt;
    logic         clk;
    logic         rst;
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    logic         valid;

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] prev_ct;
    logic [7:0]   sbox_tab [256];

    aes128_iter_encrypt dut (
        .i_AES_clk            (clk),
        .i_AES_rst            (rst),
        .i_AES_plain_text     (pt),
        .i_AES_key_in         (key),
        .o_AES_data_encrypted (ct),
        .o_AES_valid          (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box derived from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_tab[a] = s;
        end
    endtask

    function automatic logic [127:0] ref_aes(input logic [127:0] p_in, input logic [127:0] k_in);
        logic [31:0]  w [44];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   rc, acc;
        logic [31:0]  tmp;
        logic [7:0]   coef [4];
        logic [127:0] o;
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < 4; i++) w[i] = k_in[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
                tmp ^= {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = p_in[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_tab[s[r][(c+r)%4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rnd < 10) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++) acc ^= gf_mul(coef[(k-r+4)%4], t[k][c]);
                    end else begin
                        acc = t[r][c];
                    end
                    s[r][c] = acc ^ w[4*rnd+c][31-8*r -: 8];
                end
        end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    // Entered at a negedge whose next posedge is a LOAD edge; ends at the negedge after the
    // output edge, with the inputs already set to the following block's vector.
    task automatic run_block(input string tag, input logic [127:0] b_pt, input logic [127:0] b_key,
                             input logic [127:0] exp_ct, input int chg_at,
                             input logic [127:0] n_pt, input logic [127:0] n_key);
        pt  = b_pt;
        key = b_key;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k < 11) begin
                check_val({tag, "_valid_lo"}, 128'(valid), 128'(0));
                check_val({tag, "_hold"}, ct, prev_ct);
            end else begin
                check_val({tag, "_valid_hi"}, 128'(valid), 128'(1));
                check_val({tag, "_ct"}, ct, exp_ct);
            end
            if (k == chg_at) begin
                pt  = n_pt;
                key = n_key;
            end
        end
        $display("block %s pt=%h key=%h ct=%h exp=%h", tag, b_pt, b_key, ct, exp_ct);
        prev_ct = exp_ct;
        pt  = n_pt;
        key = n_key;
    endtask

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    initial begin
        logic [127:0] cur_pt, cur_key, nxt_pt, nxt_key;
        int chg;
        build_sbox();
        check_val("model_appb", ref_aes(PT_B, KEY_B), CT_B);
        rst     = 1'b1;
        pt      = PT_B;
        key     = KEY_B;
        prev_ct = '0;

        // Reset held: outputs stay cleared, no valid pulse.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check_val("rst_held_ct", ct, 128'h0);
            check_val("rst_held_valid", 128'(valid), 128'(0));
        end
        rst = 1'b0;

        run_block("appb", PT_B, KEY_B, CT_B, 0, PT_C, KEY_C);
        run_block("appc1", PT_C, KEY_C, CT_C, 0, '0, '0);
        run_block("zero0", '0, '0, CT_Z, 0, '0, '0);
        run_block("zero1", '0, '0, CT_Z, 0, PT_B, KEY_B);

        // Inputs changed mid-block only affect the next block.
        run_block("chg_old", PT_B, KEY_B, CT_B, 3, PT_C, KEY_C);
        run_block("chg_new", PT_C, KEY_C, CT_C, 0, PT_B, KEY_B);

        // One-cycle reset when the counter reads 5 aborts the block.
        for (int k = 1; k <= 5; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_ct", ct, 128'h0);
        check_val("midrst_valid", 128'(valid), 128'(0));
        rst = 1'b0;
        prev_ct = '0;
        run_block("after_rst", PT_B, KEY_B, CT_B, 0, PT_B, KEY_B);

        cur_pt  = PT_B;
        cur_key = KEY_B;
        for (int n = 0; n < 12; n++) begin
            nxt_pt  = {$urandom, $urandom, $urandom, $urandom};
            nxt_key = {$urandom, $urandom, $urandom, $urandom};
            chg     = int'($urandom_range(0, 9));
            run_block($sformatf("rand%0d", n), cur_pt, cur_key, ref_aes(cur_pt, cur_key),
                      chg, nxt_pt, nxt_key);
            cur_pt  = nxt_pt;
            cur_key = nxt_key;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
